// File: rtl/fifo_pin_sequencer.sv
// Pin-side control front-end for the byte FIFO: synchronises the tester strobes,
// holds one pending request per strobe type and issues push/pop/flush pulses.
module fifo_pin_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int POP_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic wr_pin,
    input  logic rd_pin,
    input  logic flush_pin,
    input  logic fifo_full,
    input  logic fifo_empty,
    output logic push,
    output logic pop,
    output logic flush,
    output logic busy,
    output logic data_valid,
    output logic overflow,
    output logic underflow
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PUSH  = 3'd1;
    localparam logic [2:0] S_POP   = 3'd2;
    localparam logic [2:0] S_WAITD = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam logic [2:0] LAT_LOAD = 3'(POP_LATENCY - 1);

    logic [SYNC_STAGES-1:0] r_wrSync;
    logic [SYNC_STAGES-1:0] r_rdSync;
    logic [SYNC_STAGES-1:0] r_flSync;
    logic                   r_wrHist;
    logic                   r_rdHist;
    logic                   r_flHist;
    logic                   w_wrRise;
    logic                   w_rdRise;
    logic                   w_flRise;
    logic                   r_wrPend;
    logic                   r_rdPend;
    logic                   r_flPend;
    logic                   w_svcWr;
    logic                   w_svcRd;
    logic                   w_svcFl;
    logic [2:0]             r_state;
    logic [2:0]             w_nextState;
    logic                   r_lastOp;
    logic [2:0]             r_cnt;
    logic                   r_overflow;
    logic                   r_underflow;

    // The history flop sits after the last sync stage so each level change yields one rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrSync <= '0;
            r_rdSync <= '0;
            r_flSync <= '0;
            r_wrHist <= 1'b0;
            r_rdHist <= 1'b0;
            r_flHist <= 1'b0;
        end else begin
            r_wrSync <= {r_wrSync[SYNC_STAGES-2:0], wr_pin};
            r_rdSync <= {r_rdSync[SYNC_STAGES-2:0], rd_pin};
            r_flSync <= {r_flSync[SYNC_STAGES-2:0], flush_pin};
            r_wrHist <= r_wrSync[SYNC_STAGES-1];
            r_rdHist <= r_rdSync[SYNC_STAGES-1];
            r_flHist <= r_flSync[SYNC_STAGES-1];
        end
    end

    assign w_wrRise = r_wrSync[SYNC_STAGES-1] & ~r_wrHist;
    assign w_rdRise = r_rdSync[SYNC_STAGES-1] & ~r_rdHist;
    assign w_flRise = r_flSync[SYNC_STAGES-1] & ~r_flHist;

    always_comb begin
        w_nextState = r_state;
        w_svcWr     = 1'b0;
        w_svcRd     = 1'b0;
        w_svcFl     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_flPend) begin
                    w_nextState = S_FLUSH;
                    w_svcFl     = 1'b1;
                end else if (r_wrPend && (!r_rdPend || r_lastOp == OP_READ)) begin
                    w_nextState = S_PUSH;
                    w_svcWr     = 1'b1;
                end else if (r_rdPend) begin
                    w_nextState = S_POP;
                    w_svcRd     = 1'b1;
                end
            end
            S_PUSH:  w_nextState = S_IDLE;
            S_POP:   w_nextState = fifo_empty ? S_IDLE : S_WAITD;
            S_WAITD: w_nextState = (r_cnt == 3'd0) ? S_IDLE : S_WAITD;
            S_FLUSH: w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    // A rise landing on an already-set bit (including the edge that services it) is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPend <= 1'b0;
            r_rdPend <= 1'b0;
            r_flPend <= 1'b0;
        end else if (r_state == S_FLUSH) begin
            r_wrPend <= 1'b0;
            r_rdPend <= 1'b0;
        end else begin
            r_wrPend <= w_svcWr ? 1'b0 : (r_wrPend | w_wrRise);
            r_rdPend <= w_svcRd ? 1'b0 : (r_rdPend | w_rdRise);
            r_flPend <= w_svcFl ? 1'b0 : (r_flPend | w_flRise);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lastOp    <= OP_READ;
            r_cnt       <= 3'd0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                S_PUSH: begin
                    r_lastOp <= OP_WRITE;
                    if (fifo_full) r_overflow <= 1'b1;
                end
                S_POP: begin
                    r_lastOp <= OP_READ;
                    if (fifo_empty) r_underflow <= 1'b1;
                    else            r_cnt       <= LAT_LOAD;
                end
                S_WAITD: begin
                    if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
                end
                S_FLUSH: begin
                    r_overflow  <= 1'b0;
                    r_underflow <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign push       = (r_state == S_PUSH) & ~fifo_full;
    assign pop        = (r_state == S_POP) & ~fifo_empty;
    assign flush      = (r_state == S_FLUSH);
    assign busy       = (r_state != S_IDLE);
    assign data_valid = (r_state == S_WAITD) & (r_cnt == 3'd0);
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_fifo_pin_sequencer.sv
// Bench for fifo_pin_sequencer: directed vector table, multi-cycle corner sequences
// and random strobes checked against a planned-operation reference model.
module tb_fifo_pin_sequencer;

    localparam int SYNC = 2;
    localparam int LAT  = 3;

    logic clk = 1'b0;
    logic rst, wr_pin, rd_pin, flush_pin, fifo_full, fifo_empty;
    logic push, pop, flush, busy, data_valid, overflow, underflow;

    fifo_pin_sequencer #(.SYNC_STAGES(SYNC), .POP_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .wr_pin(wr_pin), .rd_pin(rd_pin), .flush_pin(flush_pin),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .push(push), .pop(pop),
        .flush(flush), .busy(busy), .data_valid(data_valid), .overflow(overflow),
        .underflow(underflow)
    );

    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;
    string obs;

    typedef struct {
        logic       rst, wr, rd, fl, full, empty;
        logic [6:0] exp;
    } vec_t;
    vec_t vecs[$];

    // The model keeps the raw pin samples plus a plan of per-cycle actions still to be done.
    typedef enum int {K_PUSH, K_POP, K_WAIT, K_DV, K_FLUSH} kind_t;
    kind_t plan[$];
    bit    wrQ[$], rdQ[$], flQ[$];
    bit    mWrPend, mRdPend, mFlPend, mLastWrite, mOv, mUn;

    function automatic void modelReset();
        plan.delete();
        wrQ.delete();
        rdQ.delete();
        flQ.delete();
        for (int i = 0; i <= SYNC; i++) begin
            wrQ.push_back(1'b0);
            rdQ.push_back(1'b0);
            flQ.push_back(1'b0);
        end
        mWrPend = 0; mRdPend = 0; mFlPend = 0;
        mLastWrite = 0; mOv = 0; mUn = 0;
    endfunction

    function automatic logic [6:0] modelExpect(input logic full, input logic empty);
        logic p, o, f, d;
        p = 0; o = 0; f = 0; d = 0;
        if (plan.size() > 0) begin
            case (plan[0])
                K_PUSH:  p = !full;
                K_POP:   o = !empty;
                K_FLUSH: f = 1;
                K_DV:    d = 1;
                default: ;
            endcase
        end
        return {p, o, f, logic'(plan.size() > 0), d, logic'(mOv), logic'(mUn)};
    endfunction

    function automatic void modelEdge(input logic r, input logic wr, input logic rd,
                                      input logic fl, input logic full, input logic empty);
        bit rw, rr, rf, sw, sr, sf;
        kind_t k;
        if (r) begin
            modelReset();
            return;
        end
        rw = wrQ[SYNC-1] & ~wrQ[SYNC];
        rr = rdQ[SYNC-1] & ~rdQ[SYNC];
        rf = flQ[SYNC-1] & ~flQ[SYNC];
        wrQ.push_front(wr); void'(wrQ.pop_back());
        rdQ.push_front(rd); void'(rdQ.pop_back());
        flQ.push_front(fl); void'(flQ.pop_back());
        if (plan.size() == 0) begin
            sw = 0; sr = 0; sf = 0;
            if (mFlPend) begin
                plan.push_back(K_FLUSH);
                sf = 1;
            end else if (mWrPend && !(mRdPend && mLastWrite)) begin
                plan.push_back(K_PUSH);
                sw = 1;
            end else if (mRdPend) begin
                plan.push_back(K_POP);
                for (int i = 0; i < LAT - 1; i++) plan.push_back(K_WAIT);
                plan.push_back(K_DV);
                sr = 1;
            end
            mWrPend = sw ? 0 : (mWrPend | rw);
            mRdPend = sr ? 0 : (mRdPend | rr);
            mFlPend = sf ? 0 : (mFlPend | rf);
        end else begin
            k = plan.pop_front();
            case (k)
                K_PUSH: begin
                    if (full) mOv = 1;
                    mLastWrite = 1;
                end
                K_POP: begin
                    if (empty) begin
                        mUn = 1;
                        plan.delete();
                    end
                    mLastWrite = 0;
                end
                K_FLUSH: begin
                    mOv = 0; mUn = 0; mWrPend = 0; mRdPend = 0;
                end
                default: ;
            endcase
            if (k != K_FLUSH) begin
                mWrPend |= rw;
                mRdPend |= rr;
                mFlPend |= rf;
            end
        end
    endfunction

    function automatic void checkOutput(input string name, input logic [6:0] got, input logic [6:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s at %0t: got %b expected %b (push pop flush busy dv ov un)",
                     name, $time, got, exp);
        end
    endfunction

    function automatic void checkOrder(input string name, input string got, input string exp);
        testsRun++;
        if (got != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
        end
    endfunction

    // Inputs are driven 1 time unit after the rising edge, outputs checked 2 units later.
    task automatic applyStimulus(input logic iRst, input logic iWr, input logic iRd, input logic iFl,
                                 input logic iFull, input logic iEmpty, input bit doCheck,
                                 input bit useVec, input logic [6:0] vecExp);
        logic [6:0] dutVec;
        rst = iRst; wr_pin = iWr; rd_pin = iRd; flush_pin = iFl;
        fifo_full = iFull; fifo_empty = iEmpty;
        #2;
        dutVec = {push, pop, flush, busy, data_valid, overflow, underflow};
        if (doCheck) checkOutput("model", dutVec, modelExpect(iFull, iEmpty));
        if (useVec) checkOutput("vector", dutVec, vecExp);
        if (push === 1'b1) obs = {obs, "W"};
        if (pop === 1'b1) obs = {obs, "R"};
        if (flush === 1'b1) obs = {obs, "F"};
        if (data_valid === 1'b1) obs = {obs, "D"};
        @(posedge clk);
        modelEdge(iRst, iWr, iRd, iFl, iFull, iEmpty);
        #1;
    endtask

    task automatic resetDut();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 7'd0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 7'd0);
        obs = "";
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 7'd0);
    endtask

    function automatic void addVec(input logic r, input logic wr, input logic rd, input logic fl,
                                   input logic full, input logic empty, input logic [6:0] exp);
        vec_t v;
        v.rst = r; v.wr = wr; v.rd = rd; v.fl = fl; v.full = full; v.empty = empty; v.exp = exp;
        vecs.push_back(v);
    endfunction

    logic rWr = 0, rRd = 0, rFl = 0;

    initial begin
        // Vector table: push, pop, overflow, underflow and flush in sequence.
        addVec(0,1,0,0,0,0,7'b0000000); addVec(0,1,0,0,0,0,7'b0000000);
        addVec(0,1,0,0,0,0,7'b0000000); addVec(0,0,0,0,0,0,7'b0000000);
        addVec(0,0,0,0,0,0,7'b1001000); addVec(0,0,0,0,0,0,7'b0000000);
        addVec(0,0,1,0,0,0,7'b0000000); addVec(0,0,0,0,0,0,7'b0000000);
        addVec(0,0,0,0,0,0,7'b0000000); addVec(0,0,0,0,0,0,7'b0000000);
        addVec(0,0,0,0,0,0,7'b0101000); addVec(0,0,0,0,0,0,7'b0001000);
        addVec(0,0,0,0,0,0,7'b0001000); addVec(0,0,0,0,0,0,7'b0001100);
        addVec(0,0,0,0,0,0,7'b0000000);
        addVec(0,1,0,0,1,0,7'b0000000); addVec(0,0,0,0,1,0,7'b0000000);
        addVec(0,0,0,0,1,0,7'b0000000); addVec(0,0,0,0,1,0,7'b0000000);
        addVec(0,0,0,0,1,0,7'b0001000); addVec(0,0,0,0,0,0,7'b0000010);
        addVec(0,0,1,0,0,1,7'b0000010); addVec(0,0,0,0,0,1,7'b0000010);
        addVec(0,0,0,0,0,1,7'b0000010); addVec(0,0,0,0,0,1,7'b0000010);
        addVec(0,0,0,0,0,1,7'b0001010); addVec(0,0,0,0,0,1,7'b0000011);
        addVec(0,0,0,0,0,0,7'b0000011);
        addVec(0,0,0,1,0,0,7'b0000011); addVec(0,0,0,0,0,0,7'b0000011);
        addVec(0,0,0,0,0,0,7'b0000011); addVec(0,0,0,0,0,0,7'b0000011);
        addVec(0,0,0,0,0,0,7'b0011011); addVec(0,0,0,0,0,0,7'b0000000);
        addVec(0,0,0,0,0,0,7'b0000000);

        resetDut();
        foreach (vecs[i])
            applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].fl,
                          vecs[i].full, vecs[i].empty, 1, 1, vecs[i].exp);

        // Simultaneous write/read requests alternate according to the last operation.
        resetDut();
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 0, 7'd0);
        idle(12);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 7'd0);
        idle(8);
        applyStimulus(0, 1, 1, 0, 0, 0, 1, 0, 7'd0);
        idle(12);
        checkOrder("tie_order", obs, "WRDWRDW");

        // A flush arriving with write and read swallows both.
        resetDut();
        applyStimulus(0, 1, 1, 1, 0, 0, 1, 0, 7'd0);
        idle(14);
        checkOrder("flush_wins", obs, "F");

        // Reset while waiting for pop data with a write pending.
        resetDut();
        applyStimulus(0, 0, 1, 0, 0, 0, 1, 0, 7'd0);
        idle(2);
        applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 7'd0);
        idle(2);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 7'b0001000);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 7'b0000000);
        idle(15);
        checkOrder("reset_in_waitd", obs, "R");

        // Random strobes, flags and occasional resets against the model.
        resetDut();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) rWr = ~rWr;
            if ($urandom_range(0, 3) == 0) rRd = ~rRd;
            if ($urandom_range(0, 15) == 0) rFl = ~rFl;
            applyStimulus(logic'($urandom_range(0, 299) == 0), rWr, rRd, rFl,
                          logic'($urandom_range(0, 3) == 0), logic'($urandom_range(0, 3) == 0),
                          1, 0, 7'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
